fpu_mul_result_collector: RTL and testbench

Result-side stage that sits directly downstream of the `bsg_fpu_mul` multiplier. It accepts each product and its exception flags through the multiplier's valid/yumi output handshake and buffers them in a small FIFO. It presents them to the consumer on a valid/ready interface. It also keeps sticky, software-clearable accumulated exception flags and counters of results accepted.

---
 rtl/fpu_mul_result_collector.sv | 104 ++++++++++
 tb/tb_fpu_mul_result_collector.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_mul_result_collector.sv
// Buffers bsg_fpu_mul products + flags in a FIFO, serves them valid/ready.
// In: v_i/z_i/flags, ready_i, clr_flags_i. Out: yumi_o, v_o/z_o/exc_o, fflags_o, count_o, result_cnt_o.
module fpu_mul_result_collector #(
  parameter int e_p   = 8,
  parameter int m_p   = 23,
  parameter int els_p = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     v_i,
  input  logic [e_p+m_p:0]         z_i,
  input  logic                     unimplemented_i,
  input  logic                     invalid_i,
  input  logic                     overflow_i,
  input  logic                     underflow_i,
  output logic                     yumi_o,
  output logic                     v_o,
  output logic [e_p+m_p:0]         z_o,
  output logic [3:0]               exc_o,
  input  logic                     ready_i,
  input  logic                     clr_flags_i,
  output logic [3:0]               fflags_o,
  output logic [$clog2(els_p):0]   count_o,
  output logic [31:0]              result_cnt_o
);

  localparam int W     = e_p + m_p + 1;
  localparam int PTR_W = $clog2(els_p);
  localparam int CNT_W = PTR_W + 1;

  logic [W+3:0]       mem [els_p];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [3:0]         fflags;
  logic [31:0]        result_cnt;
  logic [3:0]         flags_in;
  logic               full;
  logic               push;
  logic               pop;

  assign flags_in = {unimplemented_i, invalid_i,
                     overflow_i, underflow_i};

  // full comes from registered state only, so
  // accept never depends on the consumer.
  assign full   = (count == CNT_W'(els_p));
  assign push   = v_i & ~full;
  assign pop    = (count != '0) & ready_i;
  assign yumi_o = push;

  assign v_o          = (count != '0);
  assign z_o          = mem[rd_ptr][W-1:0];
  assign exc_o        = mem[rd_ptr][W+3:W];
  assign fflags_o     = fflags;
  assign count_o      = count;
  assign result_cnt_o = result_cnt;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < els_p; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= {flags_in, z_i};
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // A flag accepted in the same cycle as a clear
  // survives the clear.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      fflags     <= '0;
      result_cnt <= '0;
    end else begin
      fflags <= (clr_flags_i ? 4'b0 : fflags)
              | (push ? flags_in : 4'b0);
      if (push) result_cnt <= result_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_fpu_mul_result_collector.sv
// Testbench for fpu_mul_result_collector.
// Directed scenarios plus a random run against a queue model.
module tb_fpu_mul_result_collector;

  localparam int ELS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v_i = 1'b0;
  logic [31:0] z_i = '0;
  logic [3:0]  fl = '0;
  logic        ready_i = 1'b0;
  logic        clr = 1'b0;
  logic        yumi;
  logic        v_o;
  logic [31:0] z_o;
  logic [3:0]  exc_o;
  logic [3:0]  fflags;
  logic [2:0]  count;
  logic [31:0] rcnt;

  int vectors = 0;
  int errors = 0;

  logic [35:0] mq[$];
  logic [3:0]  m_ff = '0;
  logic [31:0] m_cnt = '0;
  bit          last_push = 1'b0;

  always #5 clk = ~clk;

  fpu_mul_result_collector #(
    .e_p(8), .m_p(23), .els_p(ELS)
  ) dut (
    .clk_i(clk),
    .reset_n_i(rst_n),
    .v_i(v_i),
    .z_i(z_i),
    .unimplemented_i(fl[3]),
    .invalid_i(fl[2]),
    .overflow_i(fl[1]),
    .underflow_i(fl[0]),
    .yumi_o(yumi),
    .v_o(v_o),
    .z_o(z_o),
    .exc_o(exc_o),
    .ready_i(ready_i),
    .clr_flags_i(clr),
    .fflags_o(fflags),
    .count_o(count),
    .result_cnt_o(rcnt)
  );

  // Advance one clock and apply the spec rules to the model.
  task automatic tick();
    bit push;
    bit pop;
    push = v_i && (mq.size() < ELS);
    pop  = (mq.size() != 0) && ready_i;
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back({fl, z_i});
    m_ff = (clr ? 4'b0 : m_ff) | (push ? fl : 4'b0);
    if (push) m_cnt = m_cnt + 32'd1;
    last_push = push;
    #1;
  endtask

  task automatic idle_inputs();
    v_i = 1'b0; z_i = '0; fl = '0;
    ready_i = 1'b0; clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mq.delete();
    m_ff = '0;
    m_cnt = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    do_reset();
    #1;
    vectors++;
    if (v_o !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL reset_occ v_o=%b count=%0d want 0/0", v_o, count);
    end
    vectors++;
    if (z_o !== 32'd0 || exc_o !== 4'd0) begin
      errors++;
      $display("FAIL reset_head z=%h exc=%b want 0/0", z_o, exc_o);
    end
    vectors++;
    if (fflags !== 4'd0 || rcnt !== 32'd0 || yumi !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs ff=%b cnt=%0d yumi=%b want 0",
               fflags, rcnt, yumi);
    end
  endtask

  task automatic test_basic();
    v_i = 1'b1; z_i = 32'h3E800000; fl = 4'b0; ready_i = 1'b1;
    #1;
    vectors++;
    if (yumi !== 1'b1) begin
      errors++;
      $display("FAIL basic_yumi got %b want 1", yumi);
    end
    tick();
    v_i = 1'b0;
    #1;
    vectors++;
    if (v_o !== 1'b1 || z_o !== 32'h3E800000 || exc_o !== 4'b0) begin
      errors++;
      $display("FAIL basic_head v=%b z=%h exc=%b want 1/3e800000/0",
               v_o, z_o, exc_o);
    end
    vectors++;
    if (fflags !== 4'b0 || rcnt !== 32'd1) begin
      errors++;
      $display("FAIL basic_regs ff=%b cnt=%0d want 0/1", fflags, rcnt);
    end
    tick();
  endtask

  task automatic test_overflow();
    v_i = 1'b1; z_i = 32'h7F800000; fl = 4'b0010; ready_i = 1'b0;
    tick();
    v_i = 1'b0; fl = 4'b0;
    #1;
    vectors++;
    if (exc_o !== 4'b0010 || fflags !== 4'b0010) begin
      errors++;
      $display("FAIL ovf_flags exc=%b ff=%b want 0010/0010",
               exc_o, fflags);
    end
    ready_i = 1'b1;
    tick();
    vectors++;
    if (v_o !== 1'b0 || fflags !== 4'b0010) begin
      errors++;
      $display("FAIL ovf_sticky v=%b ff=%b want 0/0010", v_o, fflags);
    end
  endtask

  task automatic test_fill_stall();
    ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      v_i = 1'b1; z_i = 32'h3F800000 + 32'(i); fl = 4'b0;
      #1;
      vectors++;
      if (yumi !== 1'b1) begin
        errors++;
        $display("FAIL fill_yumi%0d got %b want 1", i, yumi);
      end
      tick();
    end
    z_i = 32'h3F800004;
    #1;
    vectors++;
    if (yumi !== 1'b0 || count !== 3'd4) begin
      errors++;
      $display("FAIL fill_full yumi=%b count=%0d want 0/4", yumi, count);
    end
    ready_i = 1'b1;
    #1;
    vectors++;
    if (yumi !== 1'b0 || z_o !== 32'h3F800000) begin
      errors++;
      $display("FAIL fullpop_cycle yumi=%b z=%h want 0/3f800000",
               yumi, z_o);
    end
    tick();
    #1;
    vectors++;
    if (count !== 3'd3 || yumi !== 1'b1 || z_o !== 32'h3F800001) begin
      errors++;
      $display("FAIL fullpop_after count=%0d yumi=%b z=%h want 3/1/3f800001",
               count, yumi, z_o);
    end
    tick();
    v_i = 1'b0;
    for (int j = 2; j <= 4; j++) begin
      #1;
      vectors++;
      if (v_o !== 1'b1 || z_o !== 32'h3F800000 + 32'(j)) begin
        errors++;
        $display("FAIL drain%0d v=%b z=%h want 1/%h",
                 j, v_o, z_o, 32'h3F800000 + 32'(j));
      end
      tick();
    end
    vectors++;
    if (v_o !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL drain_empty v=%b count=%0d want 0/0", v_o, count);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] prev;
    prev = '0;
    ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v_i = 1'b1; z_i = $urandom; fl = 4'b0;
      #1;
      vectors++;
      if (yumi !== 1'b1) begin
        errors++;
        $display("FAIL b2b_yumi%0d got %b want 1", i, yumi);
      end
      if (i > 0) begin
        vectors++;
        if (z_o !== prev || count !== 3'd1) begin
          errors++;
          $display("FAIL b2b_head%0d z=%h count=%0d want %h/1",
                   i, z_o, count, prev);
        end
      end
      prev = z_i;
      tick();
    end
    v_i = 1'b0;
    #1;
    vectors++;
    if (z_o !== prev || v_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_last z=%h v=%b want %h/1", z_o, v_o, prev);
    end
    tick();
  endtask

  task automatic test_clr_flags();
    ready_i = 1'b1;
    v_i = 1'b1; z_i = 32'h00000001; fl = 4'b0001;
    tick();
    #1;
    vectors++;
    if (fflags !== 4'b0011) begin
      errors++;
      $display("FAIL clr_pre got %b want 0011", fflags);
    end
    z_i = 32'h00000002; fl = 4'b0100; clr = 1'b1;
    tick();
    v_i = 1'b0; fl = 4'b0; clr = 1'b0;
    #1;
    vectors++;
    if (fflags !== 4'b0100) begin
      errors++;
      $display("FAIL clr_same got %b want 0100", fflags);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v_i = 1'b1; z_i = 32'h40000000 + 32'(i); fl = 4'b1000;
      tick();
    end
    v_i = 1'b0; fl = 4'b0;
    #1;
    vectors++;
    if (count !== 3'd3 || fflags === 4'b0) begin
      errors++;
      $display("FAIL mrst_pre count=%0d ff=%b want 3/nonzero",
               count, fflags);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (v_o !== 1'b0 || count !== 3'd0 || fflags !== 4'b0) begin
      errors++;
      $display("FAIL mrst_async v=%b count=%0d ff=%b want 0/0/0",
               v_o, count, fflags);
    end
    do_reset();
    v_i = 1'b1; z_i = 32'hDEADBEEF; fl = 4'b0001;
    tick();
    v_i = 1'b0; fl = 4'b0;
    #1;
    vectors++;
    if (v_o !== 1'b1 || z_o !== 32'hDEADBEEF || exc_o !== 4'b0001 ||
        count !== 3'd1 || rcnt !== 32'd1) begin
      errors++;
      $display("FAIL mrst_post v=%b z=%h exc=%b count=%0d cnt=%0d",
               v_o, z_o, exc_o, count, rcnt);
    end
    ready_i = 1'b1;
    tick();
  endtask

  task automatic test_random();
    idle_inputs();
    for (int c = 0; c < 400; c++) begin
      if (!(v_i && !last_push)) begin
        v_i = ($urandom_range(0, 3) != 0);
        z_i = $urandom;
        fl  = 4'($urandom_range(0, 15));
      end
      ready_i = ($urandom_range(0, 2) != 0);
      clr     = ($urandom_range(0, 15) == 0);
      #1;
      vectors++;
      if (yumi !== (v_i && mq.size() < ELS)) begin
        errors++;
        $display("FAIL rnd_yumi c=%0d got %b want %b",
                 c, yumi, v_i && mq.size() < ELS);
      end
      vectors++;
      if (count !== 3'(mq.size()) || v_o !== (mq.size() != 0)) begin
        errors++;
        $display("FAIL rnd_occ c=%0d count=%0d v=%b want %0d",
                 c, count, v_o, mq.size());
      end
      vectors++;
      if (fflags !== m_ff || rcnt !== m_cnt) begin
        errors++;
        $display("FAIL rnd_regs c=%0d ff=%b cnt=%0d want %b/%0d",
                 c, fflags, rcnt, m_ff, m_cnt);
      end
      if (mq.size() != 0) begin
        vectors++;
        if ({exc_o, z_o} !== mq[0]) begin
          errors++;
          $display("FAIL rnd_head c=%0d got %h want %h",
                   c, {exc_o, z_o}, mq[0]);
        end
      end
      tick();
    end
    last_push = 1'b0;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_fill_stall();
    test_back_to_back();
    test_clr_flags();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
